msg_write: RTL and testbench
============================

Name: msg_write

Overview:
- Transmit-side counterpart of the UART/OPB message receiver.
- Accepts one OPB completion per handshake: a read result, or a write acknowledge when the optional feature is enabled.
- Serialises each completion into a 10-byte frame: Header, ADDR[31:0] MSB first, DATA[31:0] MSB first, Tail.
- Pushes the frame byte by byte into the UART TX FIFO, which feeds the UART transmitter.
- Frame encoding: read response Header=0x5B, Tail=0xA4. Write acknowledge Header=0x5A, Tail=0xA5. Tail is always the bitwise complement of Header.

Parameters:
- TIMEOUT_LIMIT, 16'd200: number of PULSE_2KHZ ticks without a successful FIFO write before the frame is aborted (100 ms).

Ports:
- OPB_CLK  in  1  system clock, 100 MHz.
- OPB_RST_N  in  1  asynchronous active-low reset.
- PULSE_2KHZ  in  1  single-OPB_CLK-cycle tick at 2 kHz, sampled synchronously.
- RSP_VALID  in  1  completion available.
- RSP_READY  out  1  block can accept a completion.
- RSP_IS_WR  in  1  1 = write acknowledge, 0 = read response.
- RSP_ADDR  in  32  OPB address of the completion.
- RSP_DATA  in  32  read data, or written data for a write acknowledge.
- TX_FIFO_WR  out  1  write strobe to the TX FIFO.
- TX_FIFO_DATA  out  8  byte to write.
- TX_FIFO_FULL  in  1  TX FIFO full.
- error_flag  out  1  one-cycle pulse when a frame is aborted on timeout.

Behaviour:
- Only one clock: OPB_CLK. Reset is OPB_RST_N, asynchronous and active-low.
- Reset values while OPB_RST_N=0:
  - state=IDLE, byte_cnt=0, timeout_cnt=0, frame register=0.
  - RSP_READY=0, TX_FIFO_WR=0, TX_FIFO_DATA=0x00, error_flag=0.
- RSP_READY is 1 only in IDLE. It is 0 during the first cycle after reset release.
- States: IDLE, SEND, DONE, ERROR.
- IDLE:
  - On RSP_VALID&&RSP_READY, capture the 10-byte frame into an 80-bit register, then go to SEND with byte_cnt=0 and timeout_cnt=0.
  - Capture order: Header, RSP_ADDR[31:24..7:0], RSP_DATA[31:24..7:0], ~Header.
  - If MSG_WRITE_WR_ACK_EN is absent and RSP_IS_WR=1, the handshake still completes. No frame is built and state stays IDLE.
- SEND:
  - TX_FIFO_WR = !TX_FIFO_FULL (combinational).
  - TX_FIFO_DATA = frame byte selected by byte_cnt. It holds that byte while TX_FIFO_FULL=1.
  - Each cycle with TX_FIFO_WR=1: byte_cnt increments and timeout_cnt clears to 0.
  - When byte index 9 is written, go to DONE.
  - Back-to-back writes are allowed: 10 consecutive cycles when the FIFO is never full.
- Timeout:
  - In SEND, each PULSE_2KHZ with no write in the same cycle increments timeout_cnt, saturating at TIMEOUT_LIMIT.
  - When timeout_cnt reaches TIMEOUT_LIMIT, go to ERROR and assert no write that cycle.
  - A write and a PULSE_2KHZ in the same cycle: the write wins and timeout_cnt clears.
- DONE: lasts 1 cycle, then IDLE. byte_cnt clears.
- ERROR: error_flag=1 for exactly 1 cycle, then IDLE. The remaining bytes are dropped, the frame register clears and byte_cnt clears.
- Latency: handshake in cycle N; first TX_FIFO_WR in cycle N+1. Accept-to-accept minimum is 12 cycles (accept, 10 writes, DONE).
- TX_FIFO_FULL is ignored outside SEND.
- RSP_* inputs are ignored when RSP_READY=0.
- Reset asserted mid-frame aborts immediately. No error_flag is raised and no further bytes are written.
- byte_cnt is 4 bits, range 0..9, and never wraps.

Optional Feature:
- Macro: MSG_WRITE_WR_ACK_EN.
- Defined: RSP_IS_WR=1 builds a write-acknowledge frame with Header=0x5A, Tail=0xA5, ADDR and DATA echoed.
- Undefined: write completions are consumed silently and only read responses (0x5B/0xA4) are framed. The RSP_IS_WR port remains present in both builds.

Test Plan:
- Read response: RSP_ADDR=0x00001004, RSP_DATA=0xDEADBEEF, FIFO never full -> 10 consecutive writes: 5B 00 00 10 04 DE AD BE EF A4, then RSP_READY=1 at accept+12.
- Backpressure: same frame with TX_FIFO_FULL held high for 5 cycles after byte 3 -> TX_FIFO_WR=0 and TX_FIFO_DATA=0x10 held throughout; the stream resumes unchanged and no bytes are lost or duplicated.
- Timeout: TX_FIFO_FULL stuck at 1 after byte 2, with 200 PULSE_2KHZ ticks -> error_flag pulses for 1 cycle, only 2 bytes are written, and the block returns to IDLE with RSP_READY=1.
- Write acknowledge with RSP_IS_WR=1, ADDR=0x20, DATA=0x12345678:
  - Macro defined -> 5A 00 00 00 20 12 34 56 78 A5.
  - Macro undefined -> no writes, RSP_READY=1 on the next cycle.
- Reset mid-frame: OPB_RST_N low after byte 4 -> all outputs go to their reset values asynchronously. After release, a new read frame is emitted complete and correct.
- Simultaneous PULSE_2KHZ and a successful write with timeout_cnt=199 -> no error; timeout_cnt clears to 0.

Source files
------------

// File: rtl/msg_write_if.sv
// rtl/msg_write_if.sv - completion handshake and TX FIFO write bus for msg_write
//
// Purpose : bundles the OPB completion handshake (RSP_*) and the UART TX FIFO
//           write port (TX_FIFO_*) of msg_write.
// Signals : RSP_VALID/RSP_READY handshake, RSP_IS_WR, RSP_ADDR[31:0],
//           RSP_DATA[31:0], TX_FIFO_WR, TX_FIFO_DATA[7:0], TX_FIFO_FULL.
// Modports: master - completion source and TX FIFO side
//           slave  - msg_write
interface msg_write_if;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic        RSP_IS_WR;
   logic [31:0] RSP_ADDR;
   logic [31:0] RSP_DATA;
   logic        TX_FIFO_WR;
   logic [7:0]  TX_FIFO_DATA;
   logic        TX_FIFO_FULL;

   modport master (
      output RSP_VALID, RSP_IS_WR, RSP_ADDR, RSP_DATA, TX_FIFO_FULL,
      input  RSP_READY, TX_FIFO_WR, TX_FIFO_DATA
   );

   modport slave (
      input  RSP_VALID, RSP_IS_WR, RSP_ADDR, RSP_DATA, TX_FIFO_FULL,
      output RSP_READY, TX_FIFO_WR, TX_FIFO_DATA
   );
endinterface

// File: rtl/msg_write.sv
// rtl/msg_write.sv - serialises OPB completions into 10-byte UART TX frames
//
// Purpose : accepts one OPB completion per handshake and pushes the frame
//           Header, ADDR[31:0] MSB first, DATA[31:0] MSB first, ~Header
//           into the UART TX FIFO. Read response 0x5B/0xA4, write
//           acknowledge 0x5A/0xA5. A frame stalled on a full FIFO for
//           TIMEOUT_LIMIT PULSE_2KHZ ticks is aborted with an error_flag pulse.
// Ports   : OPB_CLK     - system clock
//           OPB_RST_N   - asynchronous active-low reset
//           PULSE_2KHZ  - one-cycle 2 kHz tick
//           bus         - msg_write_if.slave (RSP_* handshake, TX_FIFO_* port)
//           error_flag  - one-cycle pulse on timeout abort
// Macro   : MSG_WRITE_WR_ACK_EN - when defined, write completions are framed
//           as write acknowledges; otherwise they are consumed silently.
module msg_write #(
   parameter logic [15:0] TIMEOUT_LIMIT = 16'd200
) (
   input  logic       OPB_CLK,
   input  logic       OPB_RST_N,
   input  logic       PULSE_2KHZ,
   msg_write_if.slave bus,
   output logic       error_flag
);

   typedef enum logic [1:0] {IDLE, SEND, DONE, ERROR} state_t;

   state_t      r_state;
   logic [3:0]  r_byte_cnt;
   logic [15:0] r_timeout_cnt;
   logic [79:0] r_frame;
   logic        r_rsp_ready;
   logic        r_error_flag;

   logic        w_accept;
   logic        w_build;
   logic        w_timeout;
   logic        w_write;
   logic [7:0]  w_header;

   assign w_accept = (r_state == IDLE) && r_rsp_ready && bus.RSP_VALID;

`ifdef MSG_WRITE_WR_ACK_EN
   assign w_build  = w_accept;
   assign w_header = bus.RSP_IS_WR ? 8'h5A : 8'h5B;
`else
   // Write completions still handshake but never leave IDLE.
   assign w_build  = w_accept && !bus.RSP_IS_WR;
   assign w_header = 8'h5B;
`endif

   // A saturated timeout counter blocks the write so no byte slips out
   // in the cycle the frame is being abandoned.
   assign w_timeout = (r_state == SEND) && (r_timeout_cnt >= TIMEOUT_LIMIT);
   assign w_write   = (r_state == SEND) && !bus.TX_FIFO_FULL && !w_timeout;

   assign bus.TX_FIFO_WR   = w_write;
   // The frame register shifts left on each write, so the current byte is
   // always the top byte and simply holds while the FIFO is full.
   assign bus.TX_FIFO_DATA = (r_state == SEND) ? r_frame[79:72] : 8'h00;
   assign bus.RSP_READY    = r_rsp_ready;
   assign error_flag       = r_error_flag;

   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         r_state       <= IDLE;
         r_byte_cnt    <= 4'd0;
         r_timeout_cnt <= 16'd0;
         r_frame       <= 80'd0;
         r_rsp_ready   <= 1'b0;
         r_error_flag  <= 1'b0;
      end else begin
         r_error_flag <= 1'b0;
         case (r_state)
            IDLE: begin
               r_rsp_ready <= 1'b1;
               if (w_build) begin
                  r_frame       <= {w_header, bus.RSP_ADDR, bus.RSP_DATA, ~w_header};
                  r_byte_cnt    <= 4'd0;
                  r_timeout_cnt <= 16'd0;
                  r_rsp_ready   <= 1'b0;
                  r_state       <= SEND;
               end
            end
            SEND: begin
               if (w_timeout) begin
                  r_error_flag <= 1'b1;
                  r_state      <= ERROR;
               end else if (w_write) begin
                  // A write always beats a coincident tick.
                  r_frame       <= {r_frame[71:0], 8'h00};
                  r_timeout_cnt <= 16'd0;
                  if (r_byte_cnt == 4'd9) begin
                     r_state <= DONE;
                  end else begin
                     r_byte_cnt <= r_byte_cnt + 4'd1;
                  end
               end else if (PULSE_2KHZ && (r_timeout_cnt < TIMEOUT_LIMIT)) begin
                  r_timeout_cnt <= r_timeout_cnt + 16'd1;
               end
            end
            DONE: begin
               r_byte_cnt  <= 4'd0;
               r_rsp_ready <= 1'b1;
               r_state     <= IDLE;
            end
            ERROR: begin
               r_frame       <= 80'd0;
               r_byte_cnt    <= 4'd0;
               r_timeout_cnt <= 16'd0;
               r_rsp_ready   <= 1'b1;
               r_state       <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_msg_write.sv
// tb/tb_msg_write.sv - directed self-checking testbench for msg_write
module tb_msg_write;

   logic OPB_CLK;
   logic OPB_RST_N;
   logic PULSE_2KHZ;
   logic error_flag;

   int vec;
   int miscmp;

   logic [7:0] got[$];
   int         err_cycles;

   msg_write_if bus ();

   msg_write dut (
      .OPB_CLK    (OPB_CLK),
      .OPB_RST_N  (OPB_RST_N),
      .PULSE_2KHZ (PULSE_2KHZ),
      .bus        (bus),
      .error_flag (error_flag)
   );

   initial begin
      OPB_CLK = 1'b0;
      forever #5 OPB_CLK = ~OPB_CLK;
   end

   // Byte and error-pulse monitor, sampled mid-cycle.
   always @(negedge OPB_CLK) begin
      if (bus.TX_FIFO_WR === 1'b1) got.push_back(bus.TX_FIFO_DATA);
      if (error_flag === 1'b1) err_cycles++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Presents one completion; returns at #1 after the accepting edge.
   task automatic send_rsp(input logic wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      while (bus.RSP_READY !== 1'b1 && n < 50) begin
         @(posedge OPB_CLK); #1; n++;
      end
      vec++;
      if (bus.RSP_READY !== 1'b1) begin
         $display("FAIL send_rsp_ready got=%b exp=1", bus.RSP_READY); miscmp++;
      end
      bus.RSP_VALID = 1'b1; bus.RSP_IS_WR = wr; bus.RSP_ADDR = a; bus.RSP_DATA = d;
      @(posedge OPB_CLK); #1;
      bus.RSP_VALID = 1'b0;
   endtask

   task automatic wait_ready(input int limit);
      int n;
      n = 0;
      while (bus.RSP_READY !== 1'b1 && n < limit) begin
         @(posedge OPB_CLK); #1; n++;
      end
   endtask

   task automatic test_reset;
      OPB_RST_N = 1'b0; PULSE_2KHZ = 1'b0;
      bus.RSP_VALID = 1'b0; bus.RSP_IS_WR = 1'b0; bus.RSP_ADDR = 32'd0; bus.RSP_DATA = 32'd0;
      bus.TX_FIFO_FULL = 1'b0;
      @(posedge OPB_CLK); #1; @(posedge OPB_CLK); #1;
      vec++; if (bus.RSP_READY !== 1'b0) begin $display("FAIL rst_ready got=%b exp=0", bus.RSP_READY); miscmp++; end
      vec++; if (bus.TX_FIFO_WR !== 1'b0) begin $display("FAIL rst_wr got=%b exp=0", bus.TX_FIFO_WR); miscmp++; end
      vec++; if (bus.TX_FIFO_DATA !== 8'h00) begin $display("FAIL rst_data got=%h exp=00", bus.TX_FIFO_DATA); miscmp++; end
      vec++; if (error_flag !== 1'b0) begin $display("FAIL rst_err got=%b exp=0", error_flag); miscmp++; end
      OPB_RST_N = 1'b1;
      #1;
      vec++; if (bus.RSP_READY !== 1'b0) begin $display("FAIL rst_release_ready got=%b exp=0", bus.RSP_READY); miscmp++; end
      @(posedge OPB_CLK); #1;
      vec++; if (bus.RSP_READY !== 1'b1) begin $display("FAIL idle_ready got=%b exp=1", bus.RSP_READY); miscmp++; end
   endtask

   task automatic test_read;
      logic [79:0] ef;
      ef = 80'h5B_00001004_DEADBEEF_A4;
      got.delete(); err_cycles = 0; bus.TX_FIFO_FULL = 1'b0;
      send_rsp(1'b0, 32'h0000_1004, 32'hDEAD_BEEF);
      vec++; if (bus.TX_FIFO_WR !== 1'b1 || bus.TX_FIFO_DATA !== 8'h5B) begin
         $display("FAIL read_first_write got=%b/%h exp=1/5b", bus.TX_FIFO_WR, bus.TX_FIFO_DATA); miscmp++;
      end
      for (int i = 1; i <= 11; i++) begin
         @(posedge OPB_CLK); #1;
         vec++;
         if (bus.RSP_READY !== ((i == 11) ? 1'b1 : 1'b0)) begin
            $display("FAIL read_ready_cycle%0d got=%b exp=%b", i + 1, bus.RSP_READY, (i == 11)); miscmp++;
         end
      end
      vec++; if (got.size() != 10) begin $display("FAIL read_count got=%0d exp=10", got.size()); miscmp++; end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] act;
         act = (i < got.size()) ? got[i] : 8'hxx;
         vec++;
         if (act !== ef[79-8*i -: 8]) begin
            $display("FAIL read_byte%0d got=%h exp=%h", i, act, ef[79-8*i -: 8]); miscmp++;
         end
      end
   endtask

   task automatic test_backpressure;
      logic [79:0] ef;
      ef = 80'h5B_00001004_DEADBEEF_A4;
      got.delete(); err_cycles = 0; bus.TX_FIFO_FULL = 1'b0;
      send_rsp(1'b0, 32'h0000_1004, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin @(posedge OPB_CLK); #1; end
      for (int k = 0; k < 5; k++) begin
         bus.TX_FIFO_FULL = 1'b1;
         #1;
         vec++;
         if (bus.TX_FIFO_WR !== 1'b0 || bus.TX_FIFO_DATA !== 8'h10) begin
            $display("FAIL bp_hold%0d got=%b/%h exp=0/10", k, bus.TX_FIFO_WR, bus.TX_FIFO_DATA); miscmp++;
         end
         @(posedge OPB_CLK); #1;
      end
      bus.TX_FIFO_FULL = 1'b0;
      wait_ready(30);
      vec++; if (got.size() != 10) begin $display("FAIL bp_count got=%0d exp=10", got.size()); miscmp++; end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] act;
         act = (i < got.size()) ? got[i] : 8'hxx;
         vec++;
         if (act !== ef[79-8*i -: 8]) begin
            $display("FAIL bp_byte%0d got=%h exp=%h", i, act, ef[79-8*i -: 8]); miscmp++;
         end
      end
   endtask

   task automatic test_timeout;
      got.delete(); err_cycles = 0; bus.TX_FIFO_FULL = 1'b0;
      send_rsp(1'b0, 32'h0000_1004, 32'hDEAD_BEEF);
      for (int i = 0; i < 2; i++) begin @(posedge OPB_CLK); #1; end
      bus.TX_FIFO_FULL = 1'b1;
      for (int i = 0; i < 199; i++) begin
         PULSE_2KHZ = 1'b1; @(posedge OPB_CLK); #1;
         PULSE_2KHZ = 1'b0; @(posedge OPB_CLK); #1;
      end
      vec++; if (err_cycles != 0) begin $display("FAIL to_early_err got=%0d exp=0", err_cycles); miscmp++; end
      PULSE_2KHZ = 1'b1; @(posedge OPB_CLK); #1;
      PULSE_2KHZ = 1'b0;
      for (int i = 0; i < 6; i++) begin @(posedge OPB_CLK); #1; end
      vec++; if (err_cycles != 1) begin $display("FAIL to_err_pulse got=%0d exp=1", err_cycles); miscmp++; end
      vec++; if (got.size() != 2) begin $display("FAIL to_count got=%0d exp=2", got.size()); miscmp++; end
      vec++; if (got.size() < 2 || got[0] !== 8'h5B || got[1] !== 8'h00) begin
         $display("FAIL to_bytes got=%p exp=5b 00", got); miscmp++;
      end
      vec++; if (bus.RSP_READY !== 1'b1) begin $display("FAIL to_ready got=%b exp=1", bus.RSP_READY); miscmp++; end
      bus.TX_FIFO_FULL = 1'b0;
   endtask

   task automatic test_wr_ack;
      got.delete(); err_cycles = 0; bus.TX_FIFO_FULL = 1'b0;
      send_rsp(1'b1, 32'h0000_0020, 32'h1234_5678);
`ifdef MSG_WRITE_WR_ACK_EN
      begin
         logic [79:0] ef;
         ef = 80'h5A_00000020_12345678_A5;
         wait_ready(30);
         vec++; if (got.size() != 10) begin $display("FAIL wack_count got=%0d exp=10", got.size()); miscmp++; end
         for (int i = 0; i < 10; i++) begin
            logic [7:0] act;
            act = (i < got.size()) ? got[i] : 8'hxx;
            vec++;
            if (act !== ef[79-8*i -: 8]) begin
               $display("FAIL wack_byte%0d got=%h exp=%h", i, act, ef[79-8*i -: 8]); miscmp++;
            end
         end
      end
`else
      vec++; if (bus.RSP_READY !== 1'b1) begin $display("FAIL wack_ready got=%b exp=1", bus.RSP_READY); miscmp++; end
      for (int i = 0; i < 12; i++) begin @(posedge OPB_CLK); #1; end
      vec++; if (got.size() != 0) begin $display("FAIL wack_nowrites got=%0d exp=0", got.size()); miscmp++; end
`endif
   endtask

   task automatic test_reset_mid;
      logic [79:0] ef;
      ef = 80'h5B_CAFE0000_00000001_A4;
      got.delete(); err_cycles = 0; bus.TX_FIFO_FULL = 1'b0;
      send_rsp(1'b0, 32'h0000_1004, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin @(posedge OPB_CLK); #1; end
      OPB_RST_N = 1'b0;
      #1;
      vec++;
      if (bus.RSP_READY !== 1'b0 || bus.TX_FIFO_WR !== 1'b0 || bus.TX_FIFO_DATA !== 8'h00 || error_flag !== 1'b0) begin
         $display("FAIL mid_rst_outputs got=%b/%b/%h/%b exp=0/0/00/0",
                  bus.RSP_READY, bus.TX_FIFO_WR, bus.TX_FIFO_DATA, error_flag); miscmp++;
      end
      for (int i = 0; i < 3; i++) begin @(posedge OPB_CLK); #1; end
      vec++; if (got.size() != 4) begin $display("FAIL mid_rst_count got=%0d exp=4", got.size()); miscmp++; end
      OPB_RST_N = 1'b1;
      got.delete();
      send_rsp(1'b0, 32'hCAFE_0000, 32'h0000_0001);
      wait_ready(30);
      vec++; if (err_cycles != 0) begin $display("FAIL mid_rst_err got=%0d exp=0", err_cycles); miscmp++; end
      vec++; if (got.size() != 10) begin $display("FAIL mid_rst_new_count got=%0d exp=10", got.size()); miscmp++; end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] act;
         act = (i < got.size()) ? got[i] : 8'hxx;
         vec++;
         if (act !== ef[79-8*i -: 8]) begin
            $display("FAIL mid_rst_byte%0d got=%h exp=%h", i, act, ef[79-8*i -: 8]); miscmp++;
         end
      end
   endtask

   task automatic test_pulse_write_collision;
      logic [79:0] ef;
      ef = 80'h5B_00000040_A5A5A5A5_A4;
      got.delete(); err_cycles = 0;
      bus.TX_FIFO_FULL = 1'b1;
      send_rsp(1'b0, 32'h0000_0040, 32'hA5A5_A5A5);
      for (int i = 0; i < 199; i++) begin
         PULSE_2KHZ = 1'b1; @(posedge OPB_CLK); #1;
         PULSE_2KHZ = 1'b0; @(posedge OPB_CLK); #1;
      end
      // 200th tick lands together with a successful write.
      PULSE_2KHZ = 1'b1; bus.TX_FIFO_FULL = 1'b0;
      @(posedge OPB_CLK); #1;
      PULSE_2KHZ = 1'b0; bus.TX_FIFO_FULL = 1'b1;
      vec++; if (got.size() != 1) begin $display("FAIL coll_write got=%0d exp=1", got.size()); miscmp++; end
      for (int i = 0; i < 199; i++) begin
         PULSE_2KHZ = 1'b1; @(posedge OPB_CLK); #1;
         PULSE_2KHZ = 1'b0; @(posedge OPB_CLK); #1;
      end
      for (int i = 0; i < 4; i++) begin @(posedge OPB_CLK); #1; end
      vec++; if (err_cycles != 0) begin $display("FAIL coll_no_err got=%0d exp=0", err_cycles); miscmp++; end
      bus.TX_FIFO_FULL = 1'b0;
      wait_ready(30);
      vec++; if (got.size() != 10) begin $display("FAIL coll_count got=%0d exp=10", got.size()); miscmp++; end
      for (int i = 0; i < 10; i++) begin
         logic [7:0] act;
         act = (i < got.size()) ? got[i] : 8'hxx;
         vec++;
         if (act !== ef[79-8*i -: 8]) begin
            $display("FAIL coll_byte%0d got=%h exp=%h", i, act, ef[79-8*i -: 8]); miscmp++;
         end
      end
   endtask

   initial begin
      vec = 0; miscmp = 0; err_cycles = 0;
      test_reset();
      test_read();
      test_backpressure();
      test_timeout();
      test_wr_ack();
      test_reset_mid();
      test_pulse_write_collision();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
